// File: rtl/noc_pkg.sv
// Shared constants and types for the mesh router output arbiter.
package noc_pkg;

   localparam int FLIT_W = 32;

   localparam logic [1:0] FT_HEAD = 2'b10;
   localparam logic [1:0] FT_BODY = 2'b00;
   localparam logic [1:0] FT_TAIL = 2'b01;
   localparam logic [1:0] FT_HS   = 2'b11;

   localparam logic [2:0] DIR_N  = 3'd0;
   localparam logic [2:0] DIR_E  = 3'd1;
   localparam logic [2:0] DIR_S  = 3'd2;
   localparam logic [2:0] DIR_W  = 3'd3;
   localparam logic [2:0] DIR_PE = 3'd4;

   localparam int TYPE_HI  = 31;
   localparam int TYPE_LO  = 30;
   localparam int SRC_HI   = 29;
   localparam int SRC_LO   = 26;
   localparam int DST_X_HI = 25;
   localparam int DST_X_LO = 24;
   localparam int DST_Y_HI = 23;
   localparam int DST_Y_LO = 22;
   localparam int HS_RET   = 21;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   // Increment that sticks at all-ones.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/noc_rr_pick5.sv
// Five-way round-robin picker: first request above ptr, wrapping modulo 5.
module noc_rr_pick5
   import noc_pkg::*;
(
   input  logic [4:0] req,
   input  logic [2:0] ptr,
   output logic [4:0] onehot,
   output logic [2:0] idx,
   output logic       any
);

   // Scan ptr+1, ptr+2, ... ptr+5 (mod 5) and keep the first hit.
   always_comb begin
      logic [3:0] sum;
      logic [2:0] cand;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      sum    = '0;
      cand   = '0;
      for (int k = 1; k <= 5; k++) begin
         sum  = {1'b0, ptr} + 4'(k);
         cand = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
         if (!any && req[cand]) begin
            onehot[cand] = 1'b1;
            idx          = cand;
            any          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/noc_output_arbiter.sv
// Output-port wormhole arbiter and output flit register for one mesh direction.
//
// state     | meaning
// ST_IDLE   | no packet owns the port; headers and handshakes compete
// ST_LOCKED | a packet owns the port until its tail or a wait timeout
module noc_output_arbiter
   import noc_pkg::*;
#(
   parameter logic [2:0] OUT_DIR = 3'd1,
   parameter int         N_IN    = 5,
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [159:0]        flit_in,
   input  logic [14:0]         gate_in,
   input  logic [4:0]          valid_in,
   input  logic                out_ready,
   output logic [4:0]          grant,
   output logic [FLIT_W-1:0]   flit_out,
   output logic                valid_out,
   output logic                locked,
   output logic [7:0]          err_cnt
);

   arb_state_t        state;
   logic [2:0]        ptr;
   logic [2:0]        own_idx;
   logic [7:0]        wait_cnt;

   logic [FLIT_W-1:0] flits [5];
   logic [1:0]        ftype [5];
   logic [4:0]        req;
   logic [4:0]        cand;
   logic [4:0]        pick_oh;
   logic [2:0]        pick_idx;
   logic              pick_any;

   // Unpack the input bundle and qualify requests aimed at this port.
   always_comb begin
      req  = '0;
      cand = '0;
      for (int i = 0; i < 5; i++) begin
         flits[i] = '0;
         ftype[i] = FT_BODY;
      end
      for (int i = 0; i < N_IN; i++) begin
         flits[i] = flit_in[FLIT_W*i +: FLIT_W];
         ftype[i] = flits[i][TYPE_HI:TYPE_LO];
         req[i]   = valid_in[i] && (gate_in[3*i +: 3] == OUT_DIR);
         // Only headers and handshakes may open a new grant.
         cand[i]  = req[i] && ftype[i][1];
      end
   end

   noc_rr_pick5 u_pick (
      .req    (cand),
      .ptr    (ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // Arbitration FSM with registered grant, output link and error counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         ptr       <= 3'd4;
         own_idx   <= '0;
         wait_cnt  <= '0;
         grant     <= '0;
         flit_out  <= '0;
         valid_out <= 1'b0;
         locked    <= 1'b0;
         err_cnt   <= '0;
      end else if (out_ready) begin
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  ptr       <= pick_idx;
                  flit_out  <= flits[pick_idx];
                  valid_out <= 1'b1;
                  grant     <= pick_oh;
                  if (ftype[pick_idx] == FT_HEAD) begin
                     state    <= ST_LOCKED;
                     own_idx  <= pick_idx;
                     wait_cnt <= '0;
                     locked   <= 1'b1;
                  end
               end else begin
                  valid_out <= 1'b0;
                  grant     <= '0;
                  if (|req) err_cnt <= sat_inc8(err_cnt);
               end
            end
            ST_LOCKED: begin
               if (req[own_idx]) begin
                  flit_out  <= flits[own_idx];
                  valid_out <= 1'b1;
                  wait_cnt  <= '0;
                  if (ftype[own_idx] == FT_TAIL) begin
                     state  <= ST_IDLE;
                     grant  <= '0;
                     locked <= 1'b0;
                  end
               end else begin
                  valid_out <= 1'b0;
                  if (wait_cnt == TIMEOUT - 8'd1) begin
                     state    <= ST_IDLE;
                     grant    <= '0;
                     locked   <= 1'b0;
                     wait_cnt <= '0;
                     err_cnt  <= sat_inc8(err_cnt);
                  end else begin
                     wait_cnt <= wait_cnt + 8'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter (OUT_DIR=1, TIMEOUT=4): vector table,
// directed multi-cycle sequences, and randomized traffic against a model.
module tb_noc_output_arbiter;

   localparam int TMO = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [159:0] flit_in;
   logic [14:0]  gate_in;
   logic [4:0]   valid_in;
   logic         out_ready;
   logic [4:0]   grant;
   logic [31:0]  flit_out;
   logic         valid_out;
   logic         locked;
   logic [7:0]   err_cnt;

   int n_checks = 0;
   int n_err    = 0;

   // reference model state
   int          m_ptr, m_owner, m_wait, m_err;
   bit          m_locked, m_valid;
   logic [4:0]  m_grant;
   logic [31:0] m_flit;

   noc_output_arbiter #(.OUT_DIR(3'd1), .N_IN(5), .TIMEOUT(8'(TMO))) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flit_in   (flit_in),
      .gate_in   (gate_in),
      .valid_in  (valid_in),
      .out_ready (out_ready),
      .grant     (grant),
      .flit_out  (flit_out),
      .valid_out (valid_out),
      .locked    (locked),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      int          src;
      bit          v;
      logic [2:0]  dir;
      logic [31:0] f;
      bit          rdy;
      logic [4:0]  eg;
      logic [31:0] ef;
      bit          ev;
      bit          el;
      logic [7:0]  ee;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_in();
      flit_in  = '0;
      gate_in  = '0;
      valid_in = '0;
   endtask

   task automatic set_in(input int i, input bit v, input logic [2:0] d, input logic [31:0] f);
      flit_in[32*i +: 32] = f;
      gate_in[3*i +: 3]   = d;
      valid_in[i]         = v;
   endtask

   // Behavioural reference: one port, wormhole ownership, round-robin from ptr+1.
   task automatic model_step();
      bit          rq [5];
      logic [31:0] fl [5];
      int          w, c;
      w = -1;
      for (int i = 0; i < 5; i++) begin
         fl[i] = flit_in[32*i +: 32];
         rq[i] = valid_in[i] && (gate_in[3*i +: 3] == 3'd1);
      end
      if (!rst_n) begin
         m_ptr = 4; m_owner = 0; m_wait = 0; m_err = 0;
         m_locked = 0; m_valid = 0; m_grant = '0; m_flit = '0;
      end else if (out_ready) begin
         if (!m_locked) begin
            for (int k = 1; k <= 5; k++) begin
               c = (m_ptr + k) % 5;
               if (w < 0 && rq[c] && (fl[c][31:30] == 2'b10 || fl[c][31:30] == 2'b11)) w = c;
            end
            if (w >= 0) begin
               m_ptr   = w;
               m_flit  = fl[w];
               m_valid = 1;
               m_grant = 5'(1 << w);
               if (fl[w][31:30] == 2'b10) begin
                  m_locked = 1; m_owner = w; m_wait = 0;
               end
            end else begin
               m_valid = 0;
               m_grant = '0;
               for (int i = 0; i < 5; i++)
                  if (rq[i]) w = i;
               if (w >= 0 && m_err < 255) m_err++;
            end
         end else if (rq[m_owner]) begin
            m_flit  = fl[m_owner];
            m_valid = 1;
            m_wait  = 0;
            if (fl[m_owner][31:30] == 2'b01) begin
               m_locked = 0; m_grant = '0;
            end
         end else begin
            m_valid = 0;
            m_wait++;
            if (m_wait == TMO) begin
               m_locked = 0; m_grant = '0; m_wait = 0;
               if (m_err < 255) m_err++;
            end
         end
      end
   endtask

   task automatic do_cycle(input bit chk);
      model_step();
      @(posedge clk);
      #1;
      if (chk) begin
         check("m_grant",  32'(grant),     32'(m_grant));
         check("m_flit",   flit_out,       m_flit);
         check("m_valid",  32'(valid_out), 32'(m_valid));
         check("m_locked", 32'(locked),    32'(m_locked));
         check("m_err",    32'(err_cnt),   32'(m_err));
      end
   endtask

   initial begin
      vec_t tbl [$];
      rst_n = 1'b0;
      out_ready = 1'b1;
      clear_in();

      //          rst src v  dir   flit          rdy grant     flit_out      v  l  err
      tbl.push_back('{0, 0, 0, 3'd0, 32'h0,        1, 5'b00000, 32'h00000000, 0, 0, 8'd0});
      tbl.push_back('{1, 2, 1, 3'd1, 32'h82000000, 1, 5'b00100, 32'h82000000, 1, 1, 8'd0});
      tbl.push_back('{1, 2, 1, 3'd1, 32'h02000005, 1, 5'b00100, 32'h02000005, 1, 1, 8'd0});
      tbl.push_back('{1, 2, 1, 3'd1, 32'h42000000, 1, 5'b00000, 32'h42000000, 1, 0, 8'd0});
      tbl.push_back('{1, 0, 0, 3'd0, 32'h0,        1, 5'b00000, 32'h42000000, 0, 0, 8'd0});
      tbl.push_back('{1, 1, 1, 3'd1, 32'hC2200000, 1, 5'b00010, 32'hC2200000, 1, 0, 8'd0});
      tbl.push_back('{1, 0, 0, 3'd0, 32'h0,        1, 5'b00000, 32'hC2200000, 0, 0, 8'd0});
      tbl.push_back('{1, 4, 1, 3'd1, 32'h02000001, 1, 5'b00000, 32'hC2200000, 0, 0, 8'd1});
      tbl.push_back('{1, 4, 1, 3'd2, 32'h82000000, 1, 5'b00000, 32'hC2200000, 0, 0, 8'd1});

      foreach (tbl[n]) begin
         clear_in();
         rst_n     = tbl[n].rst;
         out_ready = tbl[n].rdy;
         if (tbl[n].v) set_in(tbl[n].src, 1'b1, tbl[n].dir, tbl[n].f);
         do_cycle(0);
         check("tbl_grant",  32'(grant),     32'(tbl[n].eg));
         check("tbl_flit",   flit_out,       tbl[n].ef);
         check("tbl_valid",  32'(valid_out), 32'(tbl[n].ev));
         check("tbl_locked", 32'(locked),    32'(tbl[n].el));
         check("tbl_err",    32'(err_cnt),   32'(tbl[n].ee));
      end

      // timeout: input 0 locks then goes silent for TIMEOUT cycles
      clear_in();
      set_in(0, 1'b1, 3'd1, 32'h80000000);
      do_cycle(1);
      check("to_grant", 32'(grant), 32'h1);
      clear_in();
      for (int k = 1; k <= TMO; k++) begin
         do_cycle(1);
         check("to_locked", 32'(locked), (k < TMO) ? 32'd1 : 32'd0);
      end
      check("to_err", 32'(err_cnt), 32'd2);
      check("to_grant_rel", 32'(grant), 32'h0);

      // stall mid-packet: body held three cycles with out_ready low
      set_in(2, 1'b1, 3'd1, 32'h82000000);
      do_cycle(1);
      set_in(2, 1'b1, 3'd1, 32'h02000007);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         do_cycle(1);
         check("st_flit",  flit_out,        32'h82000000);
         check("st_valid", 32'(valid_out),  32'd1);
         check("st_grant", 32'(grant),      32'h4);
      end
      out_ready = 1'b1;
      do_cycle(1);
      check("st_resume", flit_out, 32'h02000007);
      set_in(2, 1'b1, 3'd1, 32'h42000000);
      do_cycle(1);
      clear_in();
      do_cycle(1);

      // reset while locked
      set_in(2, 1'b1, 3'd1, 32'h82000000);
      do_cycle(1);
      check("rl_locked_pre", 32'(locked), 32'd1);
      set_in(2, 1'b1, 3'd1, 32'h02000003);
      rst_n = 1'b0;
      do_cycle(1);
      check("rl_grant",  32'(grant),     32'h0);
      check("rl_valid",  32'(valid_out), 32'd0);
      check("rl_locked", 32'(locked),    32'd0);
      check("rl_err",    32'(err_cnt),   32'd0);
      rst_n = 1'b1;

      // contention: inputs 0 and 3 present headers together
      clear_in();
      set_in(0, 1'b1, 3'd1, 32'h80000000);
      set_in(3, 1'b1, 3'd1, 32'h8C000000);
      do_cycle(1);
      check("ct_first", 32'(grant), 32'h01);
      set_in(0, 1'b1, 3'd1, 32'h00000011);
      do_cycle(1);
      set_in(0, 1'b1, 3'd1, 32'h40000000);
      do_cycle(1);
      check("ct_release", 32'(locked), 32'd0);
      set_in(0, 1'b0, 3'd1, 32'h0);
      do_cycle(1);
      check("ct_second", 32'(grant), 32'h08);
      check("ct_second_flit", flit_out, 32'h8C000000);
      set_in(3, 1'b1, 3'd1, 32'h4C000000);
      do_cycle(1);
      clear_in();
      do_cycle(1);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst_n     = ($urandom_range(0, 299) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 5; i++) begin
            set_in(i, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 4)) : 3'd1,
                   32'($urandom));
         end
         do_cycle(1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
